// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto one memory port; MEM_ARBITER_RR_EN selects round-robin over fixed dcache priority.
// Latency: grant one cycle after request, completion in the cycle ramready is seen; requesters stall on iwait/dwait until then.
module mem_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          timeout_err_q, timeout_err_d;
  logic          d_req;
  logic          pick_i;
  logic          i_done, d_done;

`ifdef MEM_ARBITER_RR_EN
  logic          ptr_q, ptr_d;  // 0: dcache wins a tie, 1: icache wins a tie
`endif

  assign d_req = dREN | dWEN;

`ifdef MEM_ARBITER_RR_EN
  assign pick_i = iREN & (~d_req | ptr_q);
`else
  assign pick_i = iREN & ~d_req;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + CW'(1);
    timeout_err_d = timeout_err_q;
    i_done        = 1'b0;
    d_done        = 1'b0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = 32'h0;
    ramstore      = 32'h0;
`ifdef MEM_ARBITER_RR_EN
    ptr_d         = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_i) begin
          state_d = IACC;
        end else if (d_req) begin
          state_d = DACC;
        end
      end

      IACC: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramready) begin
            i_done  = 1'b1;
            state_d = IDLE;
`ifdef MEM_ARBITER_RR_EN
            ptr_d   = 1'b0;
`endif
          end else if (cnt_inc >= CNT_LIM) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          // a simultaneous read and write is treated as a write
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ramready) begin
            d_done  = 1'b1;
            state_d = IDLE;
`ifdef MEM_ARBITER_RR_EN
            ptr_d   = 1'b1;
`endif
          end else if (cnt_inc >= CNT_LIM) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // reset silences the memory port and both requesters in the same cycle
    if (RST) begin
      i_done   = 1'b0;
      d_done   = 1'b0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'h0;
      ramstore = 32'h0;
    end
  end

  assign iwait       = ~i_done;
  assign dwait       = ~d_done;
  assign iload       = i_done ? ramload : 32'h0;
  assign dload       = d_done ? ramload : 32'h0;
  assign timeout_err = timeout_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, default 64, max cycles a granted access waits for ramready before abort.
REQ-002 SHALL have port: CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: iREN in 1, iaddr in 32, icache read request and word address.
REQ-005 SHALL have ports: iwait out 1, iload out 32, icache stall and returned word.
REQ-006 SHALL have ports: dREN in 1, dWEN in 1, daddr in 32, dstore in 32, dcache read/write request, address, write data.
REQ-007 SHALL have ports: dwait out 1, dload out 32, dcache stall and returned word.
REQ-008 SHALL have ports: ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, single shared memory port.
REQ-009 SHALL have ports: ramload in 32, ramready in 1, memory read data and access-complete strobe.
REQ-010 SHALL have port: timeout_err out 1, sticky flag, set when any access aborts on timeout.

Function
REQ-011 SHALL implement states IDLE, IACC (icache granted), DACC (dcache granted).
REQ-012 IDLE SHALL drive ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-013 IDLE SHALL transition next cycle: to DACC if dREN|dWEN; else IACC if iREN; else stay.
REQ-014 IACC SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0, combinationally from live inputs.
REQ-015 DACC SHALL drive ramaddr=daddr, ramstore=dstore; ramWEN=dWEN; ramREN=dREN & ~dWEN (dREN&dWEN both high = write).
REQ-016 Completion: in IACC/DACC with ramready=1, granted wait SHALL be 0 that cycle, load output = ramload that cycle, next state IDLE.
REQ-017 iwait/dwait SHALL be 1 in every cycle not a completion cycle for that requester; iload/dload SHALL be 0 outside own completion cycle.
REQ-018 Grant SHALL be held until completion, abort, or timeout; never preempted by the other requester.
REQ-019 Granted requester dropping its request before ramready SHALL abort: ram strobes 0 that cycle, next state IDLE, no completion signalled.
REQ-020 Minimum latency: request in IDLE at cycle N, grant state at N+1, earliest wait deassert at N+1 if ramready=1.
REQ-021 Timeout counter SHALL clear on entering IACC/DACC, increment each granted cycle with ramready=0; on reaching TIMEOUT_CYC-1 SHALL abort (next state IDLE, wait stays 1) and set timeout_err.
REQ-022 ramready asserted in IDLE SHALL be ignored.
REQ-023 Counter width SHALL be $clog2(TIMEOUT_CYC)+1; no wrap before abort.

Reset
REQ-024 RST high at a rising edge SHALL force state IDLE, counter 0, timeout_err 0, priority pointer to dcache, aborting any in-flight access.
REQ-025 During and in the cycle after reset, outputs SHALL be: iwait=dwait=1, iload=dload=0, all ram outputs 0.

Configuration
REQ-026 Macro MEM_ARBITER_RR_EN SHALL select arbitration policy.
REQ-027 Without MEM_ARBITER_RR_EN: fixed dcache priority per REQ-013.
REQ-028 With MEM_ARBITER_RR_EN: 1-bit pointer; when both request in IDLE, grant pointer side, then pointer flips to other side on that side's completion; single requester always granted.

Verification
REQ-029 dREN=1, daddr=0x100, ramready after 3 granted cycles, ramload=0xDEADBEEF -> dwait low exactly one cycle, dload=0xDEADBEEF, iwait stays 1.
REQ-030 iREN and dWEN=1 same cycle (daddr=0x40, dstore=0x12345678), RR off -> DACC first with ramWEN=1, ramstore=0x12345678; then IACC ramaddr=iaddr.
REQ-031 RR on, both request continuously, ramready=1 each grant -> completions alternate D,I,D,I over 8 accesses.
REQ-032 TIMEOUT_CYC=8, iREN=1, ramready never -> abort after 7 granted cycles, timeout_err=1 and stays 1, iwait never low.
REQ-033 dREN dropped in 2nd DACC cycle -> ramREN 0 that cycle, IDLE next, no dwait deassert.
REQ-034 RST asserted mid-DACC -> next cycle IDLE, all ram outputs 0, dwait=1, timeout_err=0.
